// File: rtl/pcm_rdarray_reader.sv
// Issues a Read Array command to the PCM, then bursts NWORDS consecutive words
// from BASE_ADDR, presenting each on a one-cycle rd_valid strobe.
module pcm_rdarray_reader #(
  parameter logic [23:0] BASE_ADDR   = 24'h100000,
  parameter int          NWORDS      = 16,
  parameter int          WR_TIME     = 5,
  parameter int          RD_TIME     = 10,
  parameter logic [15:0] CMD_RDARRAY = 16'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        ce,
  output logic        oe,
  output logic        we,
  output logic        memrst,
  output logic [24:1] addr,
  inout  wire  [15:0] data,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic [7:0]  rd_index,
  output logic [7:0]  led
);

  localparam int         TW       = 16;
  localparam logic [7:0] LAST_IDX = 8'(NWORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD_SETUP,
    S_CMD_HOLD,
    S_CMD_RECOV,
    S_RD_SETUP,
    S_RD_WAIT,
    S_RD_RECOV,
    S_DONE
  } state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [7:0]      idx;
  logic            drive_en;

  // Only the command write owns the bus; every read leaves it to the PCM.
  assign data   = drive_en ? CMD_RDARRAY : 16'hzzzz;
  assign busy   = (state != S_IDLE);
  assign memrst = 1'b1;

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every register samples pre-edge values and the strobes move with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      timer    <= '0;
      idx      <= '0;
      drive_en <= 1'b0;
      ce       <= 1'b1;
      oe       <= 1'b1;
      we       <= 1'b1;
      addr     <= BASE_ADDR;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_index <= '0;
      led      <= '0;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_CMD_SETUP;
            idx      <= '0;
            ce       <= 1'b0;
            we       <= 1'b0;
            oe       <= 1'b1;
            addr     <= BASE_ADDR;
            drive_en <= 1'b1;
          end
        end
        S_CMD_SETUP: begin
          timer <= TW'(WR_TIME);
          state <= S_CMD_HOLD;
        end
        S_CMD_HOLD: begin
          if (timer == '0) begin
            state    <= S_CMD_RECOV;
            ce       <= 1'b1;
            we       <= 1'b1;
            drive_en <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_CMD_RECOV: begin
          state <= S_RD_SETUP;
          ce    <= 1'b0;
          oe    <= 1'b0;
          addr  <= BASE_ADDR + 24'(idx);
        end
        S_RD_SETUP: begin
          timer <= TW'(RD_TIME);
          state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          // Capture on the last edge that still has oe low.
          if (timer == '0) begin
            rd_data  <= data;
            rd_index <= idx;
            rd_valid <= 1'b1;
            state    <= S_RD_RECOV;
            ce       <= 1'b1;
            oe       <= 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_RD_RECOV: begin
          if (idx == LAST_IDX) begin
            led   <= rd_data[7:0];
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            idx   <= idx + 8'd1;
            state <= S_RD_SETUP;
            ce    <= 1'b0;
            oe    <= 1'b0;
            addr  <= BASE_ADDR + 24'(idx) + 24'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state    <= S_IDLE;
          ce       <= 1'b1;
          oe       <= 1'b1;
          we       <= 1'b1;
          drive_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
